// File: rtl/fetcher_pkg.sv
// Shared core definitions: core FSM state encodings, fetch FSM states, fetch constants.
package fetcher_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } core_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;   // addi x0,x0,0

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetcher_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetcher_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetcher.sv
// Purpose: RV32I fetch stage; owns PC, fetches one word per FETCH epoch, flags misaligned PCs.
// Latency: fetch_done 3 cycles after FETCH is seen (+1 per memory stall); misaligned fault in 1.
// Backpressure: imem_req/imem_addr held stable until imem_ready; rvalid honoured only in WAIT.
module fetcher
    import fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic        pc_we,
    input  logic [31:0] next_pc,
    fetcher_if.master   imem,
    output logic [31:0] instr_raw,
    output logic [31:0] pc,
    output logic        fetch_done,
    output logic        fetch_err
);

    fetch_state_t r_fsm;
    fetch_state_t w_fsm_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_done;
    logic         r_err;
    logic         w_fetch;
    logic         w_capture;
    logic         w_fault;

    assign w_fetch = (state == FETCH);

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_capture = 1'b0;
        w_fault   = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (w_fetch) begin
                    if (word_aligned(r_pc)) begin
                        w_fsm_nxt = REQ;
                    end else begin
                        w_fsm_nxt = DONE;
                        w_fault   = 1'b1;
                    end
                end
            end
            // Request stays up until accepted, even if the core has left FETCH.
            REQ: begin
                if (imem.imem_ready) begin
                    w_fsm_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    w_fsm_nxt = DONE;
                    w_capture = 1'b1;
                end
            end
            DONE: begin
                if (!w_fetch) begin
                    w_fsm_nxt = IDLE;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_fsm  <= w_fsm_nxt;
            r_done <= w_capture | w_fault;
            if (w_capture) begin
                r_instr <= imem.imem_rdata;
                r_err   <= 1'b0;
            end else if (w_fault) begin
                r_instr <= NOP_INSTR;
                r_err   <= 1'b1;
            end
            // Redirects land between fetches; alignment is judged at the next fetch.
            if (pc_we && !w_fetch) begin
                r_pc <= next_pc;
            end
        end
    end

    assign imem.imem_req  = (r_fsm == REQ);
    assign imem.imem_addr = r_pc;
    assign instr_raw      = r_instr;
    assign pc             = r_pc;
    assign fetch_done     = r_done;
    assign fetch_err      = r_err;

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for the fetch stage with a queue scoreboard of expected fetch results.
module tb_fetcher;
    import fetcher_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  state;
    logic        pc_we;
    logic [31:0] next_pc;
    logic [31:0] instr_raw;
    logic [31:0] pc;
    logic        fetch_done;
    logic        fetch_err;

    fetcher_if imem_if ();

    fetcher dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .pc_we      (pc_we),
        .next_pc    (next_pc),
        .imem       (imem_if),
        .instr_raw  (instr_raw),
        .pc         (pc),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] addr, input logic err);
        exp_t e;
        e.instr = instr;
        e.pc    = addr;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".instr"}, instr_raw, e.instr);
            chk({tag, ".pc"},    pc,        e.pc);
            chk({tag, ".err"},   {31'd0, fetch_err}, {31'd0, e.err});
        end
    endtask

    task automatic redirect(input logic [31:0] addr);
        state   = EXEC;
        pc_we   = 1'b1;
        next_pc = addr;
        tick;
        pc_we   = 1'b0;
        chk("redirect.pc", pc, addr);
    endtask

    // One aligned fetch; k counts cycles after edge t, returns to DECODE afterwards.
    task automatic fetch_mem(input logic [31:0] exp_addr, input int rdy_dly, input int rv_dly,
                             input logic [31:0] data, input int exp_lat,
                             input bit stray_on_accept, input bit try_pc_we, input string tag);
        int k;
        state = FETCH;
        if (try_pc_we) begin
            pc_we   = 1'b1;
            next_pc = 32'h0000_0200;
        end
        tick;
        k = 1;
        chk({tag, ".req"},  {31'd0, imem_if.imem_req}, 32'd1);
        chk({tag, ".addr"}, imem_if.imem_addr, exp_addr);
        imem_if.imem_ready = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            tick;
            k++;
            chk({tag, ".req_held"},  {31'd0, imem_if.imem_req}, 32'd1);
            chk({tag, ".addr_held"}, imem_if.imem_addr, exp_addr);
        end
        imem_if.imem_ready = 1'b1;
        if (stray_on_accept) begin
            imem_if.imem_rvalid = 1'b1;
            imem_if.imem_rdata  = 32'hDEAD_BEEF;
        end
        tick;
        k++;
        imem_if.imem_ready  = 1'b0;
        imem_if.imem_rvalid = 1'b0;
        chk({tag, ".req_dropped"}, {31'd0, imem_if.imem_req}, 32'd0);
        for (int i = 0; i < rv_dly; i++) begin
            tick;
            k++;
        end
        imem_if.imem_rvalid = 1'b1;
        imem_if.imem_rdata  = data;
        push(data, exp_addr, 1'b0);
        tick;
        k++;
        imem_if.imem_rvalid = 1'b0;
        while (!fetch_done && k < exp_lat + 6) begin
            tick;
            k++;
        end
        chk({tag, ".latency"}, k, exp_lat);
        pop_check(tag);
        pc_we = 1'b0;
        state = DECODE;
        tick;
        chk({tag, ".done_pulse"}, {31'd0, fetch_done}, 32'd0);
    endtask

    task automatic fetch_misaligned(input logic [31:0] addr, input string tag);
        redirect(addr);
        state = FETCH;
        tick;
        chk({tag, ".no_req"}, {31'd0, imem_if.imem_req}, 32'd0);
        chk({tag, ".done"},   {31'd0, fetch_done}, 32'd1);
        push(NOP_INSTR, addr, 1'b1);
        pop_check(tag);
        tick;
        chk({tag, ".no_req2"}, {31'd0, imem_if.imem_req}, 32'd0);
        chk({tag, ".done_pulse"}, {31'd0, fetch_done}, 32'd0);
        state = DECODE;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req;
        int n_done;

        rst                 = 1'b1;
        state               = DECODE;
        pc_we               = 1'b0;
        next_pc             = 32'd0;
        imem_if.imem_ready  = 1'b0;
        imem_if.imem_rvalid = 1'b0;
        imem_if.imem_rdata  = 32'd0;
        tick;
        tick;
        chk("reset.pc",    pc, 32'h0000_0000);
        chk("reset.instr", instr_raw, 32'h0000_0013);
        chk("reset.req",   {31'd0, imem_if.imem_req}, 32'd0);
        chk("reset.done",  {31'd0, fetch_done}, 32'd0);
        chk("reset.err",   {31'd0, fetch_err}, 32'd0);
        rst = 1'b0;
        tick;

        fetch_mem(32'h0000_0000, 0, 0, 32'h0050_0093, 3, 1'b0, 1'b0, "basic");

        redirect(32'h0000_0100);
        fetch_mem(32'h0000_0100, 0, 0, 32'h00A0_0113, 3, 1'b0, 1'b1, "redirect");

        redirect(32'h0000_0104);
        fetch_mem(32'h0000_0104, 3, 2, 32'h0030_8193, 8, 1'b1, 1'b0, "backpressure");

        fetch_misaligned(32'h0000_0102, "misaligned");

        redirect(32'h0000_0108);
        fetch_mem(32'h0000_0108, 0, 0, 32'h0041_0213, 3, 1'b0, 1'b0, "err_clear");

        // Reset while a response is outstanding, with fetch_err set beforehand.
        fetch_misaligned(32'h0000_0003, "misaligned2");
        redirect(32'h0000_010C);
        state              = FETCH;
        imem_if.imem_ready = 1'b1;
        tick;
        tick;
        imem_if.imem_ready = 1'b0;
        rst   = 1'b1;
        state = DECODE;
        tick;
        rst = 1'b0;
        chk("rst_wait.pc",    pc, 32'h0000_0000);
        chk("rst_wait.instr", instr_raw, 32'h0000_0013);
        chk("rst_wait.req",   {31'd0, imem_if.imem_req}, 32'd0);
        chk("rst_wait.done",  {31'd0, fetch_done}, 32'd0);
        chk("rst_wait.err",   {31'd0, fetch_err}, 32'd0);
        chk("rst_wait.fsm",   {30'd0, dut.r_fsm}, {30'd0, IDLE});

        imem_if.imem_rvalid = 1'b1;
        imem_if.imem_rdata  = 32'hBAD0_0BAD;
        tick;
        imem_if.imem_rvalid = 1'b0;
        chk("stray.instr", instr_raw, 32'h0000_0013);
        chk("stray.done",  {31'd0, fetch_done}, 32'd0);

        // Whole FETCH epoch with memory always ready and always valid.
        state               = FETCH;
        imem_if.imem_ready  = 1'b1;
        imem_if.imem_rvalid = 1'b1;
        imem_if.imem_rdata  = 32'h0000_0513;
        push(32'h0000_0513, 32'h0000_0000, 1'b0);
        n_req  = 0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (imem_if.imem_req) n_req++;
            if (fetch_done) begin
                n_done++;
                pop_check("epoch");
            end
        end
        chk("epoch.n_req",  n_req, 1);
        chk("epoch.n_done", n_done, 1);
        imem_if.imem_ready  = 1'b0;
        imem_if.imem_rvalid = 1'b0;
        state               = DECODE;
        tick;

        chk("sb.drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetcher.md
# fetcher

Instruction fetch stage of the multi-cycle RV32I core, directly upstream of the decoder. Owns the program counter, runs a request/response handshake with instruction memory while the core FSM is in FETCH, and presents the captured 32-bit word plus its PC to the decoder. It accepts a redirected PC from the execute/write-back stages between fetches and flags misaligned fetch addresses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, word presented on a faulted fetch (`addi x0,x0,0`).

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `state`  in  3  core FSM state; FETCH encoding comes from the shared package.
- `pc_we`  in  1  load `next_pc` into PC; honoured only when `state != FETCH`.
- `next_pc`  in  32  redirect/sequential PC from the execute/write-back stage.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  32  word address; equals `pc`, stable while `imem_req`=1.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.
- `instr_raw`  out  32  fetched word to the decoder.
- `pc`  out  32  PC of `instr_raw`.
- `fetch_done`  out  1  one-cycle pulse: `instr_raw` updated.
- `fetch_err`  out  1  last fetch was misaligned; held until the next fetch completes.

## Operation
- Reset values: `pc`=RESET_PC, `instr_raw`=NOP_INSTR, `imem_req`=0, `fetch_done`=0, `fetch_err`=0, FSM=IDLE.
- FSM states:
  - IDLE: if `state==FETCH`, go to DONE when `pc[1:0]!=0` (fault), otherwise go to REQ.
  - REQ: `imem_req`=1; on `imem_ready`=1 go to WAIT.
  - WAIT: on `imem_rvalid`=1 capture `imem_rdata` into `instr_raw`, clear `fetch_err`, pulse `fetch_done`, go to DONE.
  - DONE: go to IDLE when `state != FETCH`; otherwise stay. This gives exactly one fetch per FETCH epoch.
- Fault path: `instr_raw`=NOP_INSTR and `fetch_err`=1, with `fetch_done` pulsed on entry to DONE. No memory request is issued.
- `imem_rvalid` is ignored outside WAIT. This includes the acceptance cycle in REQ, so the minimum memory latency is 1 cycle after acceptance.
- `imem_req` is never withdrawn before `imem_ready`, even if `state` leaves FETCH.
- `pc_we` while `state==FETCH` is ignored. `pc_we` in any other state loads `next_pc` unconditionally, aligned or not; the alignment check happens at the next fetch.
- The fetcher never increments PC itself. Sequential `pc+4` is supplied on `next_pc` by downstream logic.
- Reset mid-operation (REQ or WAIT): FSM goes to IDLE and any in-flight response is discarded. Instruction memory shares `rst`.

## Timing
- Reference point: edge t is the first edge with `state==FETCH` in IDLE.
- `imem_req` is high from cycle t+1.
- With `imem_ready` high at t+1 and `imem_rvalid` high at t+2: `instr_raw` is valid and `fetch_done`=1 in cycle t+3.
- Minimum latency is therefore 3 cycles; each memory wait cycle adds 1.
- Fault: `fetch_done` is high in cycle t+1.
- `instr_raw`, `pc` and `fetch_err` are held until the next capture. The decoder samples them in DECODE.

## Structure
- Shared package/header (existing `def.h` contents, FETCH/DECODE/... encodings) gains the fetch FSM enum (IDLE, REQ, WAIT, DONE) and the NOP constant.
- Single module, no sub-module. The handshake is small enough to inline.

## Test plan
- **Basic fetch.** Reset, then `state`=FETCH; memory has ready=1 immediately and rvalid one cycle later with rdata=32'h0050_0093. Required: `imem_addr`=0, `fetch_done` at t+3, `instr_raw`=32'h0050_0093, `pc`=0.
- **Backpressure.** `imem_ready` held low for 3 cycles, rvalid delayed by 2 cycles. Required: `imem_req` and `imem_addr` stay stable throughout; `fetch_done` at t+8.
- **Redirect.** `pc_we`=1 with `next_pc`=32'h0000_0100 during EXEC, followed by FETCH. Required: `imem_addr`=32'h100. A `pc_we` with `next_pc`=32'h200 applied during FETCH must leave `pc` unchanged.
- **Misaligned.** `next_pc`=32'h0000_0102. Required: no `imem_req`, `fetch_done` at t+1, `fetch_err`=1, `instr_raw`=32'h0000_0013. The next aligned fetch clears `fetch_err`.
- **Reset and stray responses.** Assert `rst` in WAIT. Required: all outputs return to reset values and the FSM is IDLE. A stray `imem_rvalid` with `state`=DECODE leaves `instr_raw` unchanged.
- **One fetch per epoch.** `state` held at FETCH for 10 cycles. Required: exactly one request and one `fetch_done`.
